// File: rtl/usb_pkg.sv
// Shared definitions for the USB read-side burst path.
//   - scheduler state encoding (IDLE / XFER / DONE)
//   - FX2 endpoint select codes for fx2_fifoadr
//   - USB high-speed bulk packet size
package usb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] FX2_EP2 = 2'b00;
   localparam logic [1:0] FX2_EP4 = 2'b01;
   localparam logic [1:0] FX2_EP6 = 2'b10;
   localparam logic [1:0] FX2_EP8 = 2'b11;

   localparam int USB_PKT_BYTES = 512;

endpackage

// File: rtl/usb_skid_fifo.sv
// Small byte FIFO catching buffer read data that is already in flight when
// the FX2 FIFO applies back-pressure.
//   usbdataclk  clock
//   rst_n       synchronous active-low reset (empties the FIFO)
//   wr_en/wr_data  push one byte
//   rd_en       pop the head byte (only when avail)
//   rd_data     head byte; falls through from wr_data when empty
//   avail       a byte can be popped this cycle (stored or arriving)
//   occ         number of stored bytes
module usb_skid_fifo #(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          usbdataclk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          avail,
   output logic [CW-1:0] occ
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][7:0] mem;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Fall-through: an arriving byte can leave in the same cycle, which keeps
   // the stream at one byte per clock without an extra bubble.
   assign avail   = (occ != '0) || wr_en;
   assign rd_data = (occ == '0) ? wr_data : mem[rd_ptr];

   always_ff @(posedge usbdataclk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         // A bypassed byte is still written; rd_ptr advances past it together.
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + CW'(wr_en) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/usb_burst_sched.sv
// Read-side scheduler for the ping-pong sample buffers. Each buffer-full
// request runs one BURST_LEN-byte burst: addresses go to the buffer read
// port, returned bytes stream into the FX2 slave FIFO under flag back-pressure.
//   usbdataclk, rst_n        clock, synchronous active-low reset
//   send_go, enable          burst request (rising edge), start permission
//   usbdadd / usbdata        buffer read address / data (RD_LAT later)
//   fx2_flagb                FX2 almost-full, active low
//   fx2_fifoadr, fx2_slwr_n, fx2_pktend_n, fx2_fd   FX2 slave FIFO pins
//   busy, overrun, burst_cnt status
module usb_burst_sched
   import usb_pkg::*;
#(
   parameter  int         BURST_LEN = 2048,
   parameter  int         RD_LAT    = 1,
   parameter  logic [1:0] FIFO_EP   = FX2_EP6,
   localparam int         AW        = $clog2(BURST_LEN)
) (
   input  logic          usbdataclk,
   input  logic          rst_n,
   input  logic          send_go,
   input  logic          enable,
   output logic [AW-1:0] usbdadd,
   input  logic [7:0]    usbdata,
   input  logic          fx2_flagb,
   output logic [1:0]    fx2_fifoadr,
   output logic          fx2_slwr_n,
   output logic          fx2_pktend_n,
   output logic [7:0]    fx2_fd,
   output logic          busy,
   output logic          overrun,
   output logic [15:0]   burst_cnt
);

   localparam int   CW          = AW + 1;
   localparam int   SD          = RD_LAT + 1;
   localparam int   SCW         = $clog2(SD + 1);
   localparam logic NEED_PKTEND = (BURST_LEN % USB_PKT_BYTES) != 0;

   logic [1:0]     state;
   logic           send_go_d;
   logic           pending;
   logic [RD_LAT:0] vld_pipe;      // [0] aligns with usbdadd, [RD_LAT] with usbdata
   logic [CW-1:0]  issued_cnt;
   logic [CW-1:0]  pop_cnt;

   logic           go_rise;
   logic           start;
   logic           issue;
   logic           pop;
   logic           xfer_done;
   int             held;

   logic [7:0]     skid_head;
   logic           skid_avail;
   logic [SCW-1:0] skid_occ;

   usb_skid_fifo #(.DEPTH(SD)) u_skid (
      .usbdataclk (usbdataclk),
      .rst_n      (rst_n),
      .wr_en      (vld_pipe[RD_LAT]),
      .wr_data    (usbdata),
      .rd_en      (pop),
      .rd_data    (skid_head),
      .avail      (skid_avail),
      .occ        (skid_occ)
   );

   always_comb begin
      go_rise   = send_go & ~send_go_d;
      start     = (state == ST_IDLE) && pending && enable;
      pop       = skid_avail && fx2_flagb;
      // Bytes that will need a skid slot: stored + every read still in the
      // pipe (including the one landing now), minus the one leaving now.
      // Issuing only while this is below the skid depth guarantees no overflow
      // even if the flag drops and stays low.
      held      = int'(skid_occ) + $countones(vld_pipe) - int'(pop);
      issue     = (state == ST_XFER) && (issued_cnt < CW'(BURST_LEN)) && (held < SD);
      // pop_cnt reaches BURST_LEN in the cycle the last slwr is on the pins.
      xfer_done = (state == ST_XFER) && (pop_cnt == CW'(BURST_LEN));
   end

   always_ff @(posedge usbdataclk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         send_go_d    <= 1'b0;
         pending      <= 1'b0;
         vld_pipe     <= '0;
         issued_cnt   <= '0;
         pop_cnt      <= '0;
         usbdadd      <= '0;
         fx2_fifoadr  <= FIFO_EP;
         fx2_slwr_n   <= 1'b1;
         fx2_pktend_n <= 1'b1;
         fx2_fd       <= '0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         burst_cnt    <= '0;
      end else begin
         send_go_d   <= send_go;
         vld_pipe    <= {vld_pipe[RD_LAT-1:0], issue};
         fx2_fifoadr <= FIFO_EP;

         // A new edge wins over the consume so a request landing on the
         // start cycle is kept for the next burst.
         if (go_rise)    pending <= 1'b1;
         else if (start) pending <= 1'b0;
         if (go_rise && pending && !start) overrun <= 1'b1;

         case (state)
            ST_IDLE: if (start) begin
               state      <= ST_XFER;
               busy       <= 1'b1;
               issued_cnt <= '0;
               pop_cnt    <= '0;
            end
            ST_XFER: if (xfer_done) state <= ST_DONE;
            ST_DONE: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               burst_cnt <= burst_cnt + 16'd1;
            end
            default: state <= ST_IDLE;
         endcase

         // Last address is always the final issue, so it shows for one cycle
         // and the buffer's bank toggle fires once per burst.
         if (issue) begin
            usbdadd    <= issued_cnt[AW-1:0];
            issued_cnt <= issued_cnt + CW'(1);
         end else if (issued_cnt == CW'(BURST_LEN)) begin
            usbdadd <= '0;
         end

         if (pop) begin
            fx2_fd  <= skid_head;
            pop_cnt <= pop_cnt + CW'(1);
         end
         fx2_slwr_n   <= ~pop;
         fx2_pktend_n <= ~(NEED_PKTEND && xfer_done && !pop);
      end
   end

endmodule

// File: tb/tb_usb_burst_sched.sv
module tb_usb_burst_sched;

   localparam int BL  = 2048;
   localparam int BLB = 1000;

   logic usbdataclk = 1'b0;
   always #5 usbdataclk = ~usbdataclk;

   logic        rst_n, send_go, enable, fx2_flagb;
   logic [10:0] usbdadd;
   logic [7:0]  usbdata, fx2_fd;
   logic [1:0]  fx2_fifoadr;
   logic        fx2_slwr_n, fx2_pktend_n, busy, overrun;
   logic [15:0] burst_cnt;

   logic        send_go_b, enable_b, flagb_b;
   logic [9:0]  usbdadd_b;
   logic [7:0]  usbdata_b, fd_b;
   logic [1:0]  fifoadr_b;
   logic        slwr_b, pktend_b, busy_b, overrun_b;
   logic [15:0] burst_cnt_b;

   usb_burst_sched #(.BURST_LEN(BL)) u_dut (
      .usbdataclk(usbdataclk), .rst_n(rst_n), .send_go(send_go), .enable(enable),
      .usbdadd(usbdadd), .usbdata(usbdata), .fx2_flagb(fx2_flagb),
      .fx2_fifoadr(fx2_fifoadr), .fx2_slwr_n(fx2_slwr_n), .fx2_pktend_n(fx2_pktend_n),
      .fx2_fd(fx2_fd), .busy(busy), .overrun(overrun), .burst_cnt(burst_cnt));

   usb_burst_sched #(.BURST_LEN(BLB)) u_dut_b (
      .usbdataclk(usbdataclk), .rst_n(rst_n), .send_go(send_go_b), .enable(enable_b),
      .usbdadd(usbdadd_b), .usbdata(usbdata_b), .fx2_flagb(flagb_b),
      .fx2_fifoadr(fifoadr_b), .fx2_slwr_n(slwr_b), .fx2_pktend_n(pktend_b),
      .fx2_fd(fd_b), .busy(busy_b), .overrun(overrun_b), .burst_cnt(burst_cnt_b));

   // Buffer content pattern and one-cycle-latency read port models
   function automatic logic [7:0] pat(input int a);
      return 8'((a * 37 + (a >> 8) * 11 + 5) & 255);
   endfunction

   always @(posedge usbdataclk) begin
      usbdata   <= pat(int'(usbdadd));
      usbdata_b <= pat(int'(usbdadd_b));
   end

   int compared = 0;
   int mismatched = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_q_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_a(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(pat(i));
   endtask

   // ---------------- monitor for the 2048-byte instance ----------------
   int cyc = 0, wr_cnt = 0, a2047_cnt = 0, flag_low_wr = 0, pkt_low_a = 0;
   int t_rise = 0, t_first = 0;
   bit first_seen = 1'b0;
   logic busy_prev = 1'b0, flag_prev = 1'b1;
   logic [10:0] addr_prev = '0;

   always @(negedge usbdataclk) begin
      cyc++;
      if (rst_n) begin
         if (busy && !busy_prev) begin
            t_rise = cyc; first_seen = 1'b0; wr_cnt = 0; a2047_cnt = 0;
         end
         if (!fx2_slwr_n) begin
            wr_cnt++;
            if (!first_seen) begin first_seen = 1'b1; t_first = cyc; end
            if (exp_q.size() == 0) check("extra_write", 1, 0);
            else check("fd_byte", 32'(fx2_fd), 32'(exp_q.pop_front()));
            if (!fx2_flagb) flag_low_wr++;
         end
         if (usbdadd == 11'd2047) begin
            a2047_cnt++;
            check("addr2047_one_cycle", 32'(addr_prev == 11'd2047), 0);
         end
         if (!fx2_pktend_n) pkt_low_a++;
         if (fx2_flagb && !flag_prev) begin
            check("wr_after_flag_fall_le1", 32'(flag_low_wr <= 1), 1);
            flag_low_wr = 0;
         end
      end
      busy_prev = busy; flag_prev = fx2_flagb; addr_prev = usbdadd;
   end

   // ---------------- monitor for the 1000-byte instance ----------------
   int wr_b = 0, pkt_low_b = 0;
   always @(negedge usbdataclk) begin
      if (rst_n) begin
         if (!slwr_b) begin
            wr_b++;
            if (exp_q_b.size() == 0) check("b_extra_write", 1, 0);
            else check("b_fd_byte", 32'(fd_b), 32'(exp_q_b.pop_front()));
         end
         if (!pktend_b) begin
            pkt_low_b++;
            check("b_pktend_vs_slwr", 32'(slwr_b), 1);
            check("b_pktend_in_done", 32'(busy_b), 1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_go();
      @(posedge usbdataclk); #1 send_go = 1'b1;
      @(posedge usbdataclk); #1 send_go = 1'b0;
   endtask

   // Pulse, then return just after the negedge where busy is first seen high.
   task automatic go_and_wait();
      int k = 0;
      pulse_go();
      while (!busy && k < 50) begin @(negedge usbdataclk); k++; end
      #1;
      check("busy_rise_timeout", 32'(busy), 1);
   endtask

   task automatic wait_wr(input int n);
      int k = 0;
      while (wr_cnt < n && k < 6000) begin @(negedge usbdataclk); #1; k++; end
      check("wait_wr_timeout", 32'(wr_cnt >= n), 1);
   endtask

   // Number of negedge samples from the first busy-high sample until busy low.
   task automatic run_len(output int n);
      int k = 0;
      n = 0;
      while (!busy && k < 50) begin @(negedge usbdataclk); k++; end
      while (busy && n < 6000) begin @(negedge usbdataclk); n++; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, k;
      rst_n = 1'b0; send_go = 1'b0; enable = 1'b1; fx2_flagb = 1'b1;
      send_go_b = 1'b0; enable_b = 1'b1; flagb_b = 1'b1;

      // Reset values
      repeat (3) @(posedge usbdataclk);
      @(negedge usbdataclk);
      check("rst_usbdadd", 32'(usbdadd), 0);
      check("rst_slwr_n", 32'(fx2_slwr_n), 1);
      check("rst_pktend_n", 32'(fx2_pktend_n), 1);
      check("rst_fd", 32'(fx2_fd), 0);
      check("rst_fifoadr", 32'(fx2_fifoadr), 2);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_burst_cnt", 32'(burst_cnt), 0);
      check("rst_b_pktend_n", 32'(pktend_b), 1);
      @(posedge usbdataclk); #1 rst_n = 1'b1;

      // 1: single burst, no back-pressure
      push_a(BL);
      run_len(n);
      pulse_go();
      run_len(n);
      check("burst_cycles", n, BL + 1 + 3);
      check("first_slwr_latency", t_first - t_rise, 3);
      check("addr2047_count", a2047_cnt, 1);
      @(negedge usbdataclk);
      check("addr_after_burst", 32'(usbdadd), 0);
      check("burst_cnt_1", 32'(burst_cnt), 1);
      check("queue_empty_1", exp_q.size(), 0);
      check("no_pktend_2048", pkt_low_a, 0);

      // 2: flag low for 10 cycles at byte 700 and byte 2046
      push_a(BL);
      go_and_wait();
      wait_wr(700);
      fx2_flagb = 1'b0;
      repeat (10) @(posedge usbdataclk);
      #1 fx2_flagb = 1'b1;
      wait_wr(2046);
      fx2_flagb = 1'b0;
      repeat (10) @(posedge usbdataclk);
      #1 fx2_flagb = 1'b1;
      run_len(n);
      @(negedge usbdataclk);
      check("addr2047_count_2", a2047_cnt, 1);
      check("burst_cnt_2", 32'(burst_cnt), 2);
      check("queue_empty_2", exp_q.size(), 0);

      // 3: three edges -> back-to-back bursts and overrun
      push_a(BL); push_a(BL);
      go_and_wait();
      wait_wr(500);
      pulse_go();
      @(negedge usbdataclk);
      check("overrun_after_2nd", 32'(overrun), 0);
      wait_wr(1000);
      pulse_go();
      @(negedge usbdataclk);
      check("overrun_after_3rd", 32'(overrun), 1);
      run_len(n);
      k = 0;
      while (!busy && k < 50) begin @(negedge usbdataclk); k++; end
      check("b2b_idle_gap", k, 1);
      run_len(n);
      check("burst_cycles_b2b", n, BL + 1 + 3);
      @(negedge usbdataclk);
      check("burst_cnt_3", 32'(burst_cnt), 4);
      check("overrun_sticky", 32'(overrun), 1);
      check("queue_empty_3", exp_q.size(), 0);

      // 4: enable low holds the request pending in IDLE
      enable = 1'b0;
      pulse_go();
      repeat (20) @(negedge usbdataclk);
      check("en_low_busy", 32'(busy), 0);
      check("en_low_pending", 32'(u_dut.pending), 1);
      push_a(BL);
      @(posedge usbdataclk); #1 enable = 1'b1;
      @(negedge usbdataclk);
      check("en_rise_same_cycle", 32'(busy), 0);
      @(negedge usbdataclk);
      check("en_rise_next_cycle", 32'(busy), 1);
      run_len(n);
      @(negedge usbdataclk);
      check("burst_cnt_4", 32'(burst_cnt), 5);
      check("queue_empty_4", exp_q.size(), 0);

      // 5: reset mid-burst at byte 1000, then restart from address 0
      push_a(BL);
      go_and_wait();
      wait_wr(1000);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge usbdataclk);
      check("abort_slwr_n", 32'(fx2_slwr_n), 1);
      check("abort_usbdadd", 32'(usbdadd), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_burst_cnt", 32'(burst_cnt), 0);
      @(posedge usbdataclk); #1 rst_n = 1'b1;
      push_a(BL);
      go_and_wait();
      run_len(n);
      @(negedge usbdataclk);
      check("restart_burst_cnt", 32'(burst_cnt), 1);
      check("restart_addr2047", a2047_cnt, 1);
      check("queue_empty_5", exp_q.size(), 0);

      // 6: 1000-byte build issues one pktend
      for (int i = 0; i < BLB; i++) exp_q_b.push_back(pat(i));
      @(posedge usbdataclk); #1 send_go_b = 1'b1;
      @(posedge usbdataclk); #1 send_go_b = 1'b0;
      k = 0;
      while (!busy_b && k < 50) begin @(negedge usbdataclk); k++; end
      k = 0;
      while (busy_b && k < 3000) begin @(negedge usbdataclk); k++; end
      check("b_burst_cycles", k, BLB + 1 + 3);
      check("b_bytes_written", wr_b, BLB);
      check("b_pktend_pulses", pkt_low_b, 1);
      check("b_burst_cnt", 32'(burst_cnt_b), 1);
      check("b_queue_empty", exp_q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
